// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch-stage PC owner.
// Reset PC / flush depth defaults, counter width, state flags.
package pc_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam int          DEF_FLUSH_DEPTH = 2;
    localparam int          CNT_W           = 3;

    // Fetch status: HOLD and DRAIN are independent flags
    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_HOLD       = 2'b01,
        ST_DRAIN      = 2'b10,
        ST_HOLD_DRAIN = 2'b11
    } fetch_state_e;

    // Flush depth narrowed to the counter width
    function automatic logic [CNT_W-1:0] depth_cnt(input int d);
        return d[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pc_pending_latch.sv
// Holds a redirect that arrived while fetch was blocked.
// A later set overwrites (last wins); consume clears the flag.
module pc_pending_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic        consume,
    input  logic [31:0] target_in,
    input  logic        flush_in,
    output logic        pend,
    output logic [31:0] pend_target,
    output logic        pend_flush
);

    // Capture or overwrite the blocked redirect; drop it once fetch advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= 1'b0;
            pend_target <= 32'h0;
            pend_flush  <= 1'b0;
        end else if (set) begin
            pend        <= 1'b1;
            pend_target <= target_in;
            pend_flush  <= flush_in;
        end else if (consume) begin
            pend        <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC owner: redirects, wait states, stalls, IF/ID flush.
// Optional REDIRECT_COUNT_EN adds an applied-redirect counter.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter int          FLUSH_DEPTH = DEF_FLUSH_DEPTH
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX_CONTROL,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        REG_FLUSH,
    input  logic        BUSYWAIT,
    input  logic        HAZARD_STALL,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4,
    output logic        FETCH_FLUSH,
    output logic        FETCH_VALID,
    output logic [31:0] REDIRECT_COUNT
);

    localparam logic [CNT_W-1:0] DEPTH = depth_cnt(FLUSH_DEPTH);

    logic             advance;
    logic             apply_direct;
    logic             apply_pend;
    logic             applied;
    logic             applied_flush;
    logic             pend;
    logic [31:0]      pend_target;
    logic             pend_flush;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] flush_cnt;

    assign advance       = ~BUSYWAIT;
    assign apply_direct  = advance & PC_MUX_CONTROL;
    assign apply_pend    = advance & ~PC_MUX_CONTROL & pend;
    assign applied       = apply_direct | apply_pend;
    assign applied_flush = apply_direct ? REG_FLUSH : pend_flush;

    assign PC_PLUS_4   = PC + 32'd4;
    assign FETCH_FLUSH = (flush_cnt != '0);
    assign FETCH_VALID = ~FETCH_FLUSH & ~BUSYWAIT;

    // A direct redirect on an advancing edge supersedes any pending one
    pc_pending_latch u_pend (
        .clk         (CLK),
        .rst         (RESET),
        .set         (BUSYWAIT & PC_MUX_CONTROL),
        .consume     (advance),
        .target_in   (BRANCH_OR_JUMP_ADDR),
        .flush_in    (REG_FLUSH),
        .pend        (pend),
        .pend_target (pend_target),
        .pend_flush  (pend_flush)
    );

    // Next-PC select: redirect beats pending beats stall beats increment
    always_comb begin
        pc_next = PC;
        if (apply_direct)
            pc_next = BRANCH_OR_JUMP_ADDR;
        else if (apply_pend)
            pc_next = pend_target;
        else if (advance & ~HAZARD_STALL)
            pc_next = PC_PLUS_4;
    end

    // PC register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            PC <= RESET_PC;
        else
            PC <= pc_next;
    end

    // Flush counter: reload on flushing redirect, count down while advancing
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            flush_cnt <= '0;
        else if (advance) begin
            if (applied & applied_flush)
                flush_cnt <= DEPTH;
            else if (flush_cnt != '0)
                flush_cnt <= flush_cnt - 1'b1;
        end
    end

`ifdef REDIRECT_COUNT_EN
    logic [31:0] rc_q;

    // Count every applied redirect, direct or from pending
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            rc_q <= 32'h0;
        else if (applied)
            rc_q <= rc_q + 32'd1;
    end

    assign REDIRECT_COUNT = rc_q;
`else
    assign REDIRECT_COUNT = 32'h0;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Fetch-stage program counter owner. Consumes the redirect interface driven from EX: PC_MUX_CONTROL, BRANCH_OR_JUMP_ADDR and REG_FLUSH.
- Sequences the PC against instruction-memory wait states and load-use stalls. Holds a redirect that arrives while fetch is blocked, and produces the fetch-side flush/valid qualification for the IF/ID register.
- Sits between the instruction memory and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FLUSH_DEPTH, 2: number of advancing cycles FETCH_FLUSH stays high after a flushing redirect is applied; legal range 1..7.
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PC_MUX_CONTROL  in  1  redirect request; 1 = load BRANCH_OR_JUMP_ADDR.
- BRANCH_OR_JUMP_ADDR  in  32  redirect target.
- REG_FLUSH  in  1  redirect squashes younger instructions; sampled only with PC_MUX_CONTROL=1.
- BUSYWAIT  in  1  instruction memory not ready; the pipeline is frozen.
- HAZARD_STALL  in  1  load-use stall from the hazard unit.
- PC  out  32  current fetch address (registered).
- PC_PLUS_4  out  32  PC+4, combinational, modulo 2^32.
- FETCH_FLUSH  out  1  registered; zero the IF/ID register this cycle.
- FETCH_VALID  out  1  ~FETCH_FLUSH & ~BUSYWAIT.
- REDIRECT_COUNT  out  32  accepted-redirect count (see Configuration).

## Operation
- An **advancing cycle** is one with BUSYWAIT=0.
- States:
  - RUN
  - HOLD: a redirect is latched because it arrived during BUSYWAIT.
  - DRAIN: the flush counter is nonzero.
- HOLD and DRAIN are tracked independently. The state bits are: pending flag, pending target, pending flush bit, and a 3-bit flush counter.
- PC next-value priority, highest first:
  1. RESET.
  2. Advancing cycle with PC_MUX_CONTROL=1: load BRANCH_OR_JUMP_ADDR.
  3. Advancing cycle with pending flag set: load the pending target and clear the pending flag.
  4. HAZARD_STALL=1: hold.
  5. Otherwise: PC+4.
  6. In non-advancing cycles PC holds.
- PC_MUX_CONTROL=1 with BUSYWAIT=1: latch the target and REG_FLUSH into the pending registers and set the pending flag. A later redirect while still pending overwrites them (last wins).
- The redirect beats HAZARD_STALL; the stalled instruction is on the wrong path.
- Applying a redirect whose flush bit is 1 loads the flush counter with FLUSH_DEPTH. Otherwise the counter is unaffected.
- The counter decrements on each advancing cycle while nonzero. A reload during a nonzero count restarts it at FLUSH_DEPTH.
- FETCH_FLUSH = (counter != 0).
- Target bits [1:0] pass through unmodified; alignment is the decoder's concern.

## Timing
- Reset values:
  - PC=RESET_PC
  - PC_PLUS_4=RESET_PC+4
  - FETCH_FLUSH=0
  - FETCH_VALID=1 while BUSYWAIT=0
  - REDIRECT_COUNT=0
  - pending flag=0, counter=0
- Redirect latency: PC_MUX_CONTROL sampled high at edge n with BUSYWAIT=0 gives PC=target after edge n. FETCH_FLUSH is high for the next FLUSH_DEPTH advancing cycles.
- Blocked redirect: PC becomes the target at the first edge with BUSYWAIT=0. No redirect is lost or applied twice.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- RESET asserted mid-HOLD or mid-DRAIN clears the pending flag and counter immediately (asynchronous), not at the next edge.
- BUSYWAIT and HAZARD_STALL both high: hold; BUSYWAIT governs counter freeze.

## Configuration
- REDIRECT_COUNT_EN defined: REDIRECT_COUNT increments by 1 on every applied redirect, whether direct or from pending. A blocked-then-overwritten redirect counts once when applied. The count wraps modulo 2^32.
- REDIRECT_COUNT_EN undefined: the counter register is absent and REDIRECT_COUNT is tied to 32'h0.

## Structure
- The shared package `pc_fetch_pkg` holds RESET_PC default, FLUSH_DEPTH default, the counter width (3) and the state-flag encoding.
- One sub-module, `pc_pending_latch`: pending flag/target/flush register with set, overwrite and consume controls.
- Top level contains the PC register, next-PC mux, flush counter and optional statistics counter.

## Test plan
- **Reset and run.** Assert RESET, release, BUSYWAIT=0, no redirects, 4 cycles → PC sequence 0,4,8,12,16; FETCH_FLUSH=0.
- **Direct taken branch.** At PC=8, pulse PC_MUX_CONTROL=1, REG_FLUSH=1, target 32'h1000 → PC=32'h1000 next cycle, then 1004; FETCH_FLUSH high exactly 2 cycles.
- **Blocked redirect.** BUSYWAIT=1 for 3 cycles; redirect to 32'h2000 in the 1st, then redirect to 32'h3000 in the 2nd → PC holds until BUSYWAIT falls, then becomes 32'h3000; REDIRECT_COUNT +1 when enabled.
- **Redirect over stall.** HAZARD_STALL=1 and PC_MUX_CONTROL=1 (target 32'h40, REG_FLUSH=0) → PC=32'h40; FETCH_FLUSH stays 0.
- **Wrap.** Reset with RESET_PC=32'hFFFF_FFFC, run 1 cycle → PC=32'h0; PC_PLUS_4=32'h0 at reset.
- **Asynchronous reset mid-drain.** Assert RESET between clock edges while the counter is at 1 → FETCH_FLUSH=0 and PC=RESET_PC immediately, before the next edge.
